reset_sequencer: RTL and testbench

//  Parametrised power-on/recovery reset sequencer for N_CH downstream domains (PHYs, TLK2711 lanes, user logic).

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_seq_sync.sv | 24 ++
 rtl/reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and parameter checks for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    localparam int STATE_W = 3;
    localparam int FAULT_W = 8;
    localparam int MAX_CH  = 16;

    // True when an interval can be held by a counter of the given width.
    function automatic bit interval_fits(input longint value, input int width);
        return (value >= 0) && (value < (longint'(1) << width));
    endfunction

    // True when the channel count is within the supported range.
    function automatic bit channels_ok(input int n);
        return (n >= 1) && (n <= MAX_CH);
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Multi-flop synchroniser bringing the PLL lock into the sequencer clock domain.
module reset_seq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic locked_async,
    output logic locked_sync
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous lock through the chain; cleared on reset so lock reads low.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async};
        end
    end

    assign locked_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / recovery reset sequencer: waits for stable lock, holds all
// resets, then releases channels in index order with a fixed stagger.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int LOCK_STABLE = 1000,
    parameter int HOLD_CYCLES = 50000,
    parameter int STAGGER     = 100,
    parameter int SYNC_STAGES = 2,
    parameter int USE_LOCK    = 1
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                i_locked,
    input  logic                i_soft_rst,
    output logic [N_CH-1:0]     o_rst_n,
    output logic                o_done,
    output logic [STATE_W-1:0]  o_state,
    output logic [FAULT_W-1:0]  o_fault_cnt
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // A zero LOCK_STABLE behaves like one cycle of stability.
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'((LOCK_STABLE > 0) ? LOCK_STABLE - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    // idx value at which the next stagger releases the final channel.
    localparam logic [IDX_W-1:0] IDX_PRE      = IDX_W'((N_CH > 1) ? N_CH - 2 : 0);
    localparam bit               SINGLE_CH    = (N_CH == 1);

    if (!channels_ok(N_CH)) begin : g_bad_nch
        $error("reset_sequencer: N_CH must be in 1..16");
    end
    if (!interval_fits(LOCK_STABLE, CNT_W) || !interval_fits(HOLD_CYCLES, CNT_W) ||
        !interval_fits(STAGGER, CNT_W)) begin : g_bad_interval
        $error("reset_sequencer: an interval does not fit in CNT_W bits");
    end
    if (HOLD_CYCLES == 0 || STAGGER == 0) begin : g_bad_zero
        $error("reset_sequencer: HOLD_CYCLES and STAGGER must be non-zero");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be at least 2");
    end

    seq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              lk;

    function automatic logic [FAULT_W-1:0] sat_inc(input logic [FAULT_W-1:0] v);
        return (v == '1) ? v : v + FAULT_W'(1);
    endfunction

    if (USE_LOCK != 0) begin : g_lock_sync
        reset_seq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk          (clk),
            .arst_n       (arst_n),
            .locked_async (i_locked),
            .locked_sync  (lk)
        );
    end else begin : g_lock_const
        assign lk = 1'b1;
    end

    // Sequencer FSM with shared interval counter, release index and fault counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            idx         <= '0;
            o_rst_n     <= '0;
            o_done      <= 1'b0;
            o_fault_cnt <= '0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    cnt     <= '0;
                    idx     <= '0;
                    o_rst_n <= '0;
                    o_done  <= 1'b0;
                    if (lk) state <= ST_STABLE;
                end
                ST_STABLE: begin
                    if (!lk) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!lk) begin
                        state       <= ST_WAIT_LOCK;
                        cnt         <= '0;
                        idx         <= '0;
                        o_rst_n     <= '0;
                        o_done      <= 1'b0;
                        o_fault_cnt <= sat_inc(o_fault_cnt);
                    end else if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        idx     <= '0;
                        o_rst_n <= N_CH'(1);
                        if (SINGLE_CH) begin
                            state  <= ST_RUN;
                            o_done <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (!lk) begin
                        state       <= ST_WAIT_LOCK;
                        cnt         <= '0;
                        idx         <= '0;
                        o_rst_n     <= '0;
                        o_done      <= 1'b0;
                        o_fault_cnt <= sat_inc(o_fault_cnt);
                    end else if (i_soft_rst) begin
                        state   <= ST_HOLD;
                        cnt     <= '0;
                        idx     <= '0;
                        o_rst_n <= '0;
                        o_done  <= 1'b0;
                    end else if (state == ST_RELEASE) begin
                        if (cnt == STAGGER_LAST) begin
                            // Released bits are contiguous from bit 0, so shifting in a 1 frees the next channel.
                            cnt     <= '0;
                            idx     <= idx + IDX_W'(1);
                            o_rst_n <= (o_rst_n << 1) | N_CH'(1);
                            if (idx == IDX_PRE) begin
                                state  <= ST_RUN;
                                o_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_WAIT_LOCK;
                    cnt     <= '0;
                    idx     <= '0;
                    o_rst_n <= '0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timeline model plus directed literals.
module tb_reset_sequencer;

    localparam int N_CH        = 3;
    localparam int CNT_W       = 8;
    localparam int LOCK_STABLE = 8;
    localparam int HOLD_CYCLES = 10;
    localparam int STAGGER     = 4;
    localparam int SYNC_STAGES = 2;

    logic            clk = 1'b0;
    logic            arst_n = 1'b1;
    logic            i_locked = 1'b0;
    logic            i_soft_rst = 1'b0;
    logic [N_CH-1:0] o_rst_n;
    logic            o_done;
    logic [2:0]      o_state;
    logic [7:0]      o_fault_cnt;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    reset_sequencer #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .LOCK_STABLE (LOCK_STABLE),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STAGGER     (STAGGER),
        .SYNC_STAGES (SYNC_STAGES),
        .USE_LOCK    (1)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_locked    (i_locked),
        .i_soft_rst  (i_soft_rst),
        .o_rst_n     (o_rst_n),
        .o_done      (o_done),
        .o_state     (o_state),
        .o_fault_cnt (o_fault_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference model: phase 0 = waiting for lock, 1 = lock stabilising,
    // 2 = sequencing, where m_age counts edges since the all-held point.
    int m_phase = 0;
    int m_age   = 0;
    int m_fault = 0;
    logic [SYNC_STAGES-1:0] pin_hist = '0;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_phase  <= 0;
            m_age    <= 0;
            m_fault  <= 0;
            pin_hist <= '0;
        end else begin
            pin_hist <= {pin_hist[SYNC_STAGES-2:0], i_locked};
            case (m_phase)
                0: if (pin_hist[SYNC_STAGES-1]) begin
                       m_phase <= 1;
                       m_age   <= 0;
                   end
                1: if (!pin_hist[SYNC_STAGES-1]) m_phase <= 0;
                   else if (m_age == LOCK_STABLE - 1) begin
                       m_phase <= 2;
                       m_age   <= 0;
                   end else m_age <= m_age + 1;
                default: if (!pin_hist[SYNC_STAGES-1]) begin
                       m_phase <= 0;
                       m_fault <= (m_fault < 255) ? m_fault + 1 : 255;
                   end else if (i_soft_rst && m_age >= HOLD_CYCLES) m_age <= 0;
                   else m_age <= m_age + 1;
            endcase
        end
    end

    function automatic int exp_rst(input int ph, input int age);
        int r = 0;
        if (ph == 2)
            for (int k = 0; k < N_CH; k++)
                if (age >= HOLD_CYCLES + k * STAGGER) r = r | (1 << k);
        return r;
    endfunction

    function automatic int exp_done(input int ph, input int age);
        return (ph == 2 && age >= HOLD_CYCLES + (N_CH - 1) * STAGGER) ? 1 : 0;
    endfunction

    function automatic int exp_state(input int ph, input int age);
        if (ph != 2) return ph;
        if (age < HOLD_CYCLES) return 2;
        return exp_done(ph, age) ? 4 : 3;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_rst_n", int'(o_rst_n), exp_rst(m_phase, m_age));
        chk("cyc_done", int'(o_done), exp_done(m_phase, m_age));
        chk("cyc_state", int'(o_state), exp_state(m_phase, m_age));
        chk("cyc_fault", int'(o_fault_cnt), m_fault);
    end

    task automatic at(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Raise lock now; the next edge is T. Checks the full release timeline.
    task automatic raise_and_check(input string tag);
        int t;
        i_locked = 1'b1;
        t = edge_n + 1;
        at(t + 1);  chk({tag, "_wait"}, int'(o_state), 0);
        at(t + 2);  chk({tag, "_stable"}, int'(o_state), 1);
        at(t + 9);  chk({tag, "_stable_end"}, int'(o_state), 1);
        at(t + 10); chk({tag, "_hold"}, int'(o_state), 2);
        at(t + 19); chk({tag, "_rst_000"}, int'(o_rst_n), 0);
        at(t + 20); chk({tag, "_rst_001"}, int'(o_rst_n), 1);
                    chk({tag, "_release"}, int'(o_state), 3);
        at(t + 23); chk({tag, "_rst_001b"}, int'(o_rst_n), 1);
        at(t + 24); chk({tag, "_rst_011"}, int'(o_rst_n), 3);
        at(t + 27); chk({tag, "_done_0"}, int'(o_done), 0);
        at(t + 28); chk({tag, "_rst_111"}, int'(o_rst_n), 7);
                    chk({tag, "_done_1"}, int'(o_done), 1);
                    chk({tag, "_run"}, int'(o_state), 4);
    endtask

    initial begin
        int t, d, s;
        #1 arst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rst_n", int'(o_rst_n), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_state", int'(o_state), 0);
        chk("reset_fault", int'(o_fault_cnt), 0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic power-up sequence
        raise_and_check("t1");

        // Lock loss in RUN, then re-sequence
        repeat (3) @(negedge clk);
        i_locked = 1'b0;
        d = edge_n + 1;
        at(d + 1); chk("t3_still_run", int'(o_rst_n), 7);
        at(d + 2); chk("t3_rst", int'(o_rst_n), 0);
                   chk("t3_done", int'(o_done), 0);
                   chk("t3_state", int'(o_state), 0);
                   chk("t3_fault", int'(o_fault_cnt), 1);
        repeat (3) @(negedge clk);
        raise_and_check("t3");

        // Soft reset in RUN; a soft pulse during HOLD must not restart it
        repeat (2) @(negedge clk);
        i_soft_rst = 1'b1;
        s = edge_n + 1;
        at(s);      i_soft_rst = 1'b0;
                    chk("t4_rst", int'(o_rst_n), 0);
                    chk("t4_state", int'(o_state), 2);
                    chk("t4_done", int'(o_done), 0);
        at(s + 3);  i_soft_rst = 1'b1;
        at(s + 4);  i_soft_rst = 1'b0;
        at(s + 9);  chk("t4_hold_end", int'(o_rst_n), 0);
        at(s + 10); chk("t4_rst_001", int'(o_rst_n), 1);
                    chk("t4_release", int'(o_state), 3);
                    chk("t4_fault", int'(o_fault_cnt), 1);
        at(s + 18); chk("t4_rst_111", int'(o_rst_n), 7);
                    chk("t4_run", int'(o_state), 4);

        // Soft reset coincident with synced lock loss
        repeat (2) @(negedge clk);
        i_locked = 1'b0;
        d = edge_n + 1;
        at(d + 1); i_soft_rst = 1'b1;
        at(d + 2); i_soft_rst = 1'b0;
                   chk("t6_state", int'(o_state), 0);
                   chk("t6_rst", int'(o_rst_n), 0);
                   chk("t6_fault", int'(o_fault_cnt), 2);

        // Asynchronous reset mid-release
        repeat (3) @(negedge clk);
        i_locked = 1'b1;
        t = edge_n + 1;
        at(t + 24); chk("t5_pre", int'(o_rst_n), 3);
        #2 arst_n = 1'b0;
        #1 chk("t5_rst", int'(o_rst_n), 0);
           chk("t5_fault", int'(o_fault_cnt), 0);
           chk("t5_done", int'(o_done), 0);
           chk("t5_state", int'(o_state), 0);
        @(negedge clk);
        @(negedge clk);

        // One-cycle lock glitch during STABLE restarts the count
        arst_n = 1'b1;
        t = edge_n + 1;
        at(t + 4);  i_locked = 1'b0;
        at(t + 5);  i_locked = 1'b1;
        at(t + 6);  chk("t2_stable", int'(o_state), 1);
        at(t + 7);  chk("t2_wait", int'(o_state), 0);
        at(t + 8);  chk("t2_restable", int'(o_state), 1);
        at(t + 15); chk("t2_stable_end", int'(o_state), 1);
        at(t + 16); chk("t2_hold", int'(o_state), 2);
                    chk("t2_rst", int'(o_rst_n), 0);
                    chk("t2_fault", int'(o_fault_cnt), 0);
        at(t + 26); chk("t2_rst_001", int'(o_rst_n), 1);

        // Randomised lock, soft-reset and occasional async reset activity
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i_locked) begin
                if ($urandom_range(0, 79) == 0) i_locked = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) i_locked = 1'b1;
            end
            i_soft_rst = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 arst_n = 1'b0;
                @(negedge clk);
                arst_n = 1'b1;
            end
        end

        // Force 300 lock losses; fault count must saturate
        @(negedge clk);
        i_locked   = 1'b0;
        i_soft_rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            i_locked = 1'b1;
            repeat (14) @(negedge clk);
            i_locked = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("t6_sat", int'(o_fault_cnt), 255);
        i_locked = 1'b1;
        repeat (14) @(negedge clk);
        i_locked = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_sat_hold", int'(o_fault_cnt), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
